// File: rtl/motor_pkg.sv
// Shared types and constants for the motor move sequencer and its command FIFO.
package motor_pkg;

    localparam int CNT_W_DEF      = 32;
    localparam int PER_W_DEF      = 16;
    localparam int FIFO_DEPTH_DEF = 4;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        WAIT_ACK,
        RUN
    } seq_state_t;

    // Field order matches the packed word stored in the command FIFO.
    typedef struct packed {
        logic [CNT_W_DEF-1:0] steps;
        logic                 dir;
        logic [PER_W_DEF-1:0] period;
    } motor_cmd_t;

endpackage

// File: rtl/motor_cmd_fifo.sv
// Small first-word-fall-through command queue; flush empties it in one cycle.
module motor_cmd_fifo
    import motor_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int WIDTH = CNT_W_DEF + 1 + PER_W_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_reg == (AW+1)'(DEPTH));
    assign empty   = (level_reg == '0);
    assign level   = level_reg;
    assign dout    = mem[rd_ptr_reg];
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/motor_move_sequencer.sv
// Queues move commands and hands them to the H-bridge driver through a level
// start/done handshake while generating the step-rate tick.
module motor_move_sequencer
    import motor_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int PER_W      = PER_W_DEF,
    localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             PRESERN,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic [PER_W-1:0] cmd_period,
    input  logic             abort,
    input  logic             drv_done,
    output logic             drv_start,
    output logic [CNT_W-1:0] drv_counter,
    output logic             drv_dir,
    output logic             step_tick,
    output logic             busy,
    output logic [LW-1:0]    fifo_level,
    output logic [15:0]      moves_done
);

    localparam int CMD_W = CNT_W + 1 + PER_W;

    seq_state_t       state_reg;
    logic [PER_W-1:0] period_reg;
    logic [PER_W-1:0] tick_cnt_reg;
    logic [CMD_W-1:0] head;
    logic [CNT_W-1:0] head_steps;
    logic             head_dir;
    logic [PER_W-1:0] head_period;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             tick_wrap;

    assign head_steps  = head[CMD_W-1 -: CNT_W];
    assign head_dir    = head[PER_W];
    assign head_period = head[PER_W-1:0];

    assign cmd_ready = ~fifo_full;
    assign busy      = (state_reg != IDLE) | ~fifo_empty;
    assign fifo_pop  = (state_reg == IDLE) & ~fifo_empty & drv_done & ~abort;
    assign tick_wrap = (tick_cnt_reg == period_reg - 1'b1);

    motor_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (PRESERN),
        .flush (abort),
        .push  (cmd_valid & ~abort),
        .pop   (fifo_pop),
        .din   ({cmd_steps, cmd_dir, cmd_period}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge PRESERN) begin
        if (!PRESERN) begin
            state_reg    <= IDLE;
            drv_start    <= 1'b0;
            drv_counter  <= '0;
            drv_dir      <= DIR_FWD;
            step_tick    <= 1'b0;
            moves_done   <= '0;
            tick_cnt_reg <= '0;
            period_reg   <= '0;
        end else if (abort) begin
            // The driver finishes its current phase on its own; we don't wait.
            state_reg    <= IDLE;
            drv_start    <= 1'b0;
            drv_counter  <= '0;
            step_tick    <= 1'b0;
            tick_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    step_tick    <= 1'b0;
                    tick_cnt_reg <= '0;
                    if (fifo_pop) begin
                        if (head_steps == '0) begin
                            moves_done <= moves_done + 1'b1;
                        end else begin
                            drv_counter <= head_steps;
                            drv_dir     <= head_dir;
                            period_reg  <= (head_period == '0) ? PER_W'(1) : head_period;
                            state_reg   <= DISPATCH;
                        end
                    end
                end
                DISPATCH: begin
                    drv_start <= 1'b1;
                    state_reg <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    step_tick    <= tick_wrap;
                    tick_cnt_reg <= tick_wrap ? '0 : tick_cnt_reg + 1'b1;
                    if (!drv_done) begin
                        drv_start <= 1'b0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (drv_done) begin
                        moves_done   <= moves_done + 1'b1;
                        step_tick    <= 1'b0;
                        tick_cnt_reg <= '0;
                        state_reg    <= IDLE;
                    end else begin
                        step_tick    <= tick_wrap;
                        tick_cnt_reg <= tick_wrap ? '0 : tick_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_motor_move_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_motor_move_sequencer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        PRESERN;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_steps;
    logic        cmd_dir;
    logic [15:0] cmd_period;
    logic        abort;
    logic        drv_done;
    logic        drv_start;
    logic [31:0] drv_counter;
    logic        drv_dir;
    logic        step_tick;
    logic        busy;
    logic [2:0]  fifo_level;
    logic [15:0] moves_done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    motor_move_sequencer dut (
        .clk         (clk),
        .PRESERN     (PRESERN),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_steps   (cmd_steps),
        .cmd_dir     (cmd_dir),
        .cmd_period  (cmd_period),
        .abort       (abort),
        .drv_done    (drv_done),
        .drv_start   (drv_start),
        .drv_counter (drv_counter),
        .drv_dir     (drv_dir),
        .step_tick   (step_tick),
        .busy        (busy),
        .fifo_level  (fifo_level),
        .moves_done  (moves_done)
    );

    // Reference model: a queue of commands plus the life of the current move.
    typedef struct {
        logic [31:0] steps;
        logic        dir;
        logic [15:0] per;
    } cmd_t;

    cmd_t        mq[$];
    cmd_t        m_head;
    cmd_t        m_new;
    bit          m_can_push;
    bit          m_active;   // a move has been popped and not yet completed
    bit          m_pending;  // popped, start not yet raised
    bit          m_start;
    bit          m_tick;
    bit          m_dir;
    logic [31:0] m_cnt;
    logic [15:0] m_moves;
    int          m_per;
    int          m_run;      // cycles spent since start was raised

    always @(posedge clk or negedge PRESERN) begin
        if (!PRESERN) begin
            mq.delete();
            m_active = 0; m_pending = 0; m_start = 0; m_tick = 0;
            m_dir = 1; m_cnt = 0; m_moves = 0; m_per = 1; m_run = 0;
        end else if (abort) begin
            mq.delete();
            m_active = 0; m_pending = 0; m_start = 0; m_tick = 0; m_cnt = 0;
        end else begin
            m_can_push = cmd_valid && (mq.size() < DEPTH);
            m_new = '{cmd_steps, cmd_dir, cmd_period};
            if (!m_active) begin
                m_tick = 0;
                if (mq.size() > 0 && drv_done) begin
                    m_head = mq.pop_front();
                    if (m_head.steps == 0) begin
                        m_moves = m_moves + 16'd1;
                    end else begin
                        m_active = 1; m_pending = 1;
                        m_cnt = m_head.steps;
                        m_dir = m_head.dir;
                        m_per = (m_head.per == 0) ? 1 : int'(m_head.per);
                    end
                end
            end else if (m_pending) begin
                m_pending = 0; m_start = 1; m_run = 0;
            end else if (!m_start && drv_done) begin
                m_active = 0; m_tick = 0; m_moves = m_moves + 16'd1;
            end else begin
                m_tick = ((m_run + 1) % m_per) == 0;
                m_run++;
                if (m_start && !drv_done) m_start = 0;
            end
            if (m_can_push) mq.push_back(m_new);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (PRESERN) begin
            chk("m.cmd_ready",   cmd_ready,   mq.size() < DEPTH);
            chk("m.fifo_level",  fifo_level,  mq.size());
            chk("m.busy",        busy,        m_active || mq.size() != 0);
            chk("m.drv_start",   drv_start,   m_start);
            chk("m.drv_counter", drv_counter, m_cnt);
            chk("m.drv_dir",     drv_dir,     m_dir);
            chk("m.step_tick",   step_tick,   m_tick);
            chk("m.moves_done",  moves_done,  m_moves);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [31:0] s, input logic d, input logic [15:0] p);
        cmd_steps = s; cmd_dir = d; cmd_period = p;
    endtask

    int wait_c = 0;
    int busy_c = 0;

    initial begin
        PRESERN = 0; cmd_valid = 0; abort = 0; drv_done = 1;
        set_cmd(0, 1, 0);
        step();
        chk("rst.drv_start", drv_start, 0);
        chk("rst.drv_dir", drv_dir, 1);
        chk("rst.drv_counter", drv_counter, 0);
        chk("rst.step_tick", step_tick, 0);
        chk("rst.moves_done", moves_done, 0);
        chk("rst.fifo_level", fifo_level, 0);
        chk("rst.busy", busy, 0);
        step();
        PRESERN = 1;

        // Basic move: start rises two cycles after the pop, ticks every 4th cycle.
        cmd_valid = 1; set_cmd(3, 1, 4);
        step(); cmd_valid = 0;
        chk("t1.level_after_push", fifo_level, 1);
        chk("t1.start_early", drv_start, 0);
        step();
        chk("t1.start_pop_cycle", drv_start, 0);
        chk("t1.busy", busy, 1);
        step();
        chk("t1.start_high", drv_start, 1);
        chk("t1.counter", drv_counter, 3);
        chk("t1.dir", drv_dir, 1);
        drv_done = 0;
        for (int j = 1; j <= 8; j++) begin
            step();
            if (j == 1) chk("t1.start_drop", drv_start, 0);
            chk("t1.tick", step_tick, (j % 4) == 0);
        end
        drv_done = 1;
        step();
        chk("t1.moves", moves_done, 1);
        chk("t1.idle", busy, 0);

        // Fill with the driver busy: fifth push is refused.
        drv_done = 0; cmd_valid = 1;
        for (int k = 0; k < 5; k++) begin
            set_cmd(k + 1, 1, 16'(k));
            step();
            if (k == 3) chk("t2.ready_full", cmd_ready, 0);
        end
        cmd_valid = 0;
        chk("t2.level", fifo_level, 4);
        abort = 1; step(); abort = 0;
        chk("t2.flushed", fifo_level, 0);
        drv_done = 1;

        // Zero-step move is discarded, next one dispatched with period 1.
        cmd_valid = 1; set_cmd(0, 1, 7);
        step(); set_cmd(2, 0, 1);
        step(); cmd_valid = 0;
        chk("t3.discard_moves", moves_done, 2);
        chk("t3.no_start", drv_start, 0);
        step();
        step();
        chk("t3.start", drv_start, 1);
        chk("t3.dir", drv_dir, 0);
        chk("t3.counter", drv_counter, 2);
        drv_done = 0;
        step(); chk("t3.tick1", step_tick, 1);
        step(); chk("t3.tick2", step_tick, 1);

        // Abort in RUN with two commands queued; a same-cycle push is dropped.
        cmd_valid = 1; set_cmd(5, 1, 2);
        step(); step();
        chk("t4.queued", fifo_level, 2);
        abort = 1;
        step(); abort = 0; cmd_valid = 0;
        chk("t4.level", fifo_level, 0);
        chk("t4.start", drv_start, 0);
        chk("t4.counter", drv_counter, 0);
        chk("t4.moves", moves_done, 2);
        chk("t4.busy", busy, 0);
        // Driver still finishing: dispatch must wait for drv_done.
        cmd_valid = 1; set_cmd(4, 1, 3);
        step(); cmd_valid = 0;
        step(); step();
        chk("t4.blocked", drv_start, 0);
        chk("t4.held", fifo_level, 1);
        drv_done = 1;
        step(); step();
        chk("t4.dispatched", drv_start, 1);

        // Asynchronous reset while in WAIT_ACK.
        #2 PRESERN = 0;
        #1;
        chk("t5.start", drv_start, 0);
        chk("t5.counter", drv_counter, 0);
        chk("t5.moves", moves_done, 0);
        chk("t5.busy", busy, 0);
        step(); PRESERN = 1;
        step();
        chk("t5.idle_level", fifo_level, 0);
        chk("t5.idle_busy", busy, 0);

        // Period 0 behaves as period 1.
        cmd_valid = 1; set_cmd(1, 1, 0);
        step(); cmd_valid = 0;
        step(); step();
        drv_done = 0;
        step(); chk("t6.tick1", step_tick, 1);
        step(); chk("t6.tick2", step_tick, 1);
        drv_done = 1;
        step(); chk("t6.moves", moves_done, 1);

        // Random traffic with a reactive driver.
        for (int c = 0; c < 4000; c++) begin
            abort = ($urandom_range(0, 99) == 0);
            cmd_valid = ($urandom_range(0, 2) == 0);
            set_cmd(($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 9)),
                    1'($urandom_range(0, 1)), 16'($urandom_range(0, 5)));
            if (drv_done) begin
                if (drv_start) begin
                    if (wait_c == 0) begin
                        drv_done = 0;
                        busy_c = $urandom_range(1, 10);
                    end else begin
                        wait_c--;
                    end
                end else begin
                    wait_c = $urandom_range(0, 3);
                end
            end else if (busy_c == 0) begin
                drv_done = 1;
            end else begin
                busy_c--;
            end
            step();
        end
        cmd_valid = 0; abort = 1; drv_done = 1;
        step(); abort = 0;

        // moves_done wraps after 65536 completed moves.
        PRESERN = 0; step(); PRESERN = 1;
        cmd_valid = 1; set_cmd(0, 1, 0);
        for (int n = 0; n < 65535; n++) step();
        cmd_valid = 0;
        step(); step();
        chk("t7.moves_ffff", moves_done, 16'hFFFF);
        cmd_valid = 1;
        step(); cmd_valid = 0;
        step(); step();
        chk("t7.moves_wrap", moves_done, 0);
        chk("t7.busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/motor_move_sequencer.md
Name: motor_move_sequencer

Overview:
- Command front-end that sits directly upstream of the H-bridge motor driver.
- Queues move commands (step count, direction, step period) from the fabric/APB register layer in a small FIFO.
- Hands each command to the driver through a level start/done handshake and generates the step-rate tick that paces the driver's state advance.
- Drops zero-step moves, supports abort, and keeps a completed-move count for software.

Parameters:
- FIFO_DEPTH, 4, number of queued commands; power of 2, minimum 2.
- CNT_W, 32, step-count width; matches the driver counter.
- PER_W, 16, step-period width in clk cycles.

Ports:
- clk  in  1  system clock
- PRESERN  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept; cmd_ready = !full
- cmd_steps  in  CNT_W  steps for this move
- cmd_dir  in  1  1 = forward, 0 = reverse
- cmd_period  in  PER_W  clk cycles per step tick; 0 is treated as 1
- abort  in  1  synchronous flush and stop
- drv_done  in  1  driver idle/complete flag
- drv_start  out  1  start request to the driver (the driver's fabint)
- drv_counter  out  CNT_W  step count presented to the driver
- drv_dir  out  1  direction presented to the driver
- step_tick  out  1  one-cycle step enable to the driver
- busy  out  1  high when state != IDLE or FIFO not empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- moves_done  out  16  completed-move count; wraps

Behaviour:
- Reset (async assert, sync release), all outputs and registers cleared:
  - state = IDLE; FIFO empty.
  - drv_start = 0, drv_counter = 0, drv_dir = 1, step_tick = 0.
  - moves_done = 0, tick counter = 0.
- FIFO:
  - Push on cmd_valid & cmd_ready.
  - Pop only in IDLE, per the dispatch rule below.
  - Simultaneous push and pop when full is not possible (cmd_ready = 0 when full).
  - Simultaneous push and pop when non-full: level unchanged.
  - Push while full is ignored; the upstream must honour ready.
  - Entry = {steps, dir, period}; read pointer and write pointer wrap modulo FIFO_DEPTH.
- FSM states: IDLE, DISPATCH, WAIT_ACK, RUN.
  - IDLE:
    - If the FIFO is non-empty and drv_done = 1: pop the head.
    - If the head has steps = 0: discard it, stay in IDLE, and increment moves_done. Only one pop per cycle.
    - Otherwise: latch steps into drv_counter, dir into drv_dir, period into period_r (0 becomes 1), and go to DISPATCH.
  - DISPATCH: drive drv_start = 1; go to WAIT_ACK next cycle.
  - WAIT_ACK:
    - Hold drv_start = 1 until drv_done = 0 is sampled.
    - Then drop drv_start and go to RUN.
    - This is a level handshake, so it tolerates a driver that advances only on step_tick.
  - RUN: on drv_done = 1, increment moves_done and go to IDLE.
  - Dispatch latency: 2 cycles from pop to the first drv_start high.
- step_tick:
  - The tick counter runs only in WAIT_ACK and RUN.
  - step_tick pulses for one cycle when the counter reaches period_r - 1; the counter then reloads to 0.
  - period_r = 1 gives step_tick high every cycle.
  - The counter clears on entry to IDLE.
- drv_counter and drv_dir stay stable from DISPATCH until the next dispatch.
- abort (highest priority, any state):
  - Next cycle: FIFO empty, state = IDLE, drv_start = 0, step_tick = 0, tick counter = 0.
  - moves_done is not incremented.
  - drv_counter is set to 0. The driver, which keys off its own counter, finishes at most the current 4-phase step; the sequencer does not wait for it.
  - A push in the same cycle as abort is dropped.
- Reset mid-move: everything returns to reset values immediately; no handshake completion is owed.
- drv_done low while in IDLE (driver still finishing after an abort): dispatch is blocked until drv_done = 1.

Decomposition:
- Shared package motor_pkg:
  - State enum for the sequencer FSM.
  - Command struct {steps, dir, period}.
  - Constants: DIR_FWD = 1, DIR_REV = 0, and the default widths.
- One sub-module: motor_cmd_fifo.
  - Parameterised synchronous FIFO with push/pop/full/empty/level and a synchronous flush input used by abort.
  - Instantiated once.

Test Plan:
- Reset, then push {steps=3, dir=1, period=4} with drv_done=1 → drv_start rises 2 cycles after the pop. Then drop drv_done → drv_start falls next cycle, and step_tick pulses every 4th cycle. Then raise drv_done → moves_done=1, busy=0.
- Push 5 commands with FIFO_DEPTH=4 and no dispatch (drv_done=0) → cmd_ready=0 after the 4th push; the 5th is not accepted; fifo_level=4.
- Push {steps=0} followed by {steps=2, dir=0, period=1} → the first is discarded with moves_done=1 and no drv_start. The second is dispatched with drv_dir=0, drv_counter=2, and step_tick high every cycle.
- Issue abort in RUN with 2 commands queued → next cycle: fifo_level=0, state IDLE, drv_start=0, drv_counter=0, moves_done unchanged.
- Assert PRESERN low asynchronously mid-WAIT_ACK → outputs reach reset values without a clk edge; after release, the FSM is idle with an empty FIFO.
- Set cmd_period=0 → behaves identically to period 1. Drive 65536 zero-step commands → moves_done wraps to 0.
